// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard detection and stall control for the 5-stage pipeline. It covers the
// cases the bypass network cannot: load-use, decode-stage branch/jr operand
// hazards, and occupancy of HI/LO by the iterative mult/div unit. Any hazard
// freezes F/D (StallF, StallD) and bubbles E (FlushE).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   RegisterRsD/RtD            sources of the instruction in D
//   WriteRegE/M, RegWriteE     destinations in E/M, E writes the register file
//   MemtoRegE/M                E/M instruction is a load
//   BranchD, JrD               D holds a branch (Rs, Rt) / jr (Rs only)
//   HiLoReadD, MulDivD         D holds mfhi/mflo / mult/div
//   MulDivStartE, MulDivOpE    mult/div issue in E, 0 = mult, 1 = div
//   StallF, StallD, FlushE     combinational stall/flush controls
//   MulDivBusy, MulDivDone     unit occupied / HI/LO written this cycle
//   StallCycles                count of stalled cycles (perf build only)
//
// Optional feature: define HAZARD_PERF_EN to build the StallCycles counter;
// without it StallCycles is tied to zero.
module hazard_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RegisterRsD,
  input  logic [4:0]  RegisterRtD,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        JrD,
  input  logic        HiLoReadD,
  input  logic        MulDivD,
  input  logic        MulDivStartE,
  input  logic        MulDivOpE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic [31:0] StallCycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       stall_s;

  // A jr reads only Rs, so Rt must not create a false dependency for it.
  function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic rs_only);
    logic hit;
    if (r == 5'd0) begin
      hit = 1'b0;
    end else if (rs_only) begin
      hit = (r == rs);
    end else begin
      hit = (r == rs) || (r == rt);
    end
    return hit;
  endfunction

  // Mult/div state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MulDivStartE) begin
          state_d = BUSY;
          cnt_d   = MulDivOpE ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Hazard detection and output decode; everything is forced low during reset.
  always_comb begin
    logic rs_only, lw, br, md;
    rs_only = JrD && !BranchD;
    lw = MemtoRegE && RegWriteE &&
         src_match(WriteRegE, RegisterRsD, RegisterRtD, rs_only);
    br = (BranchD || JrD) &&
         ((RegWriteE && src_match(WriteRegE, RegisterRsD, RegisterRtD, rs_only)) ||
          (MemtoRegM && src_match(WriteRegM, RegisterRsD, RegisterRtD, rs_only)));
    md = (HiLoReadD || MulDivD) && ((state_q != IDLE) || MulDivStartE);
    if (reset) begin
      stall_s    = 1'b0;
      MulDivBusy = 1'b0;
      MulDivDone = 1'b0;
    end else begin
      stall_s    = lw || br || md;
      MulDivBusy = (state_q != IDLE);
      MulDivDone = (state_q == DONE);
    end
    StallF = stall_s;
    StallD = stall_s;
    FlushE = stall_s;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Stall-cycle counter increment, wraps naturally at 2^32.
  always_comb begin
    if (stall_s) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign StallCycles = perf_q;
`else
  assign StallCycles = 32'd0;
`endif

endmodule
